// File: rtl/uart_tx_sched_pkg.sv
// Shared types and width helpers for the UART TX frame scheduler.
// Optional feature macro: UART_TX_SCHED_SOURCE_HEADER_EN (see uart_tx_frame_scheduler.sv).
package uart_tx_sched_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHeader,
        StFetch,
        StSend,
        StWaitAccept,
        StWaitDone,
        StDone,
        StGap
    } sched_state_e;

    // Index width for a buffer of max_length elements (at least 1 bit).
    function automatic int unsigned idx_width(input int unsigned max_length);
        return (max_length > 1) ? $clog2(max_length) : 1;
    endfunction

    // Length must hold the value max_length itself, hence one extra bit.
    function automatic int unsigned len_width(input int unsigned max_length);
        return idx_width(max_length) + 1;
    endfunction

    function automatic int unsigned id_width(input int unsigned num);
        return (num > 1) ? $clog2(num) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after the pointer, wrapping.
module uart_tx_rr_arbiter
    import uart_tx_sched_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = id_width(N)
) (
    input  logic [N-1:0]    i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic            o_hit,
    output logic [N-1:0]    o_grant,
    output logic [ID_W-1:0] o_idx
);

    logic [ID_W-1:0] w_cand [N];

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            w_cand[i] = ID_W'((32'(i_ptr) + i) % N);
        end
    end

    always_comb begin
        o_hit   = 1'b0;
        o_grant = '0;
        o_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!o_hit && i_req[w_cand[i]]) begin
                o_hit            = 1'b1;
                o_idx            = w_cand[i];
                o_grant[w_cand[i]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_frame_scheduler.sv
// Round-robin sharing of one byte UART transmitter among NUM_REQUESTERS frame sources.
// Define UART_TX_SCHED_SOURCE_HEADER_EN to prefix every frame with a grant_id header element.
module uart_tx_frame_scheduler
    import uart_tx_sched_pkg::*;
#(
    parameter int unsigned NUM_REQUESTERS = 4,
    parameter int unsigned ELEMENT_WIDTH  = 8,
    parameter int unsigned MAX_LENGTH     = 256,
    parameter int unsigned GAP_WIDTH      = 16,
    parameter int unsigned IDX_W          = idx_width(MAX_LENGTH),
    parameter int unsigned LEN_W          = IDX_W + 1,
    parameter int unsigned ID_W           = id_width(NUM_REQUESTERS)
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [NUM_REQUESTERS-1:0]                    i_req_valid,
    input  logic [NUM_REQUESTERS-1:0][LEN_W-1:0]         i_req_length,
    output logic [NUM_REQUESTERS-1:0]                    o_req_done,
    output logic [NUM_REQUESTERS-1:0]                    o_rd_sel,
    output logic [IDX_W-1:0]                             o_rd_index,
    input  logic [NUM_REQUESTERS-1:0][ELEMENT_WIDTH-1:0] i_rd_data,
    input  logic [GAP_WIDTH-1:0]                         i_gap_cycles,
    output logic                                         o_byte_tx_en,
    output logic [ELEMENT_WIDTH-1:0]                     o_byte_tx_data,
    input  logic                                         i_byte_tx_ready,
    output logic                                         o_busy,
    output logic [ID_W-1:0]                              o_grant_id
);

    sched_state_e               r_state, w_state_d;
    logic [ID_W-1:0]            r_ptr, w_ptr_d;
    logic [ID_W-1:0]            r_grant_id, w_grant_id_d;
    logic [NUM_REQUESTERS-1:0]  r_rd_sel, w_rd_sel_d;
    logic [IDX_W-1:0]           r_rd_index, w_rd_index_d;
    logic [LEN_W-1:0]           r_len, w_len_d;
    logic [GAP_WIDTH-1:0]       r_gap_len, w_gap_len_d;
    logic [GAP_WIDTH-1:0]       r_gap_cnt, w_gap_cnt_d;
    logic                       r_busy, w_busy_d;
    logic                       r_tx_en, w_tx_en_d;
    logic [ELEMENT_WIDTH-1:0]   r_tx_data, w_tx_data_d;
    logic [NUM_REQUESTERS-1:0]  r_req_done, w_req_done_d;
`ifdef UART_TX_SCHED_SOURCE_HEADER_EN
    logic                       r_hdr, w_hdr_d;
`endif

    logic                       w_hit;
    logic [NUM_REQUESTERS-1:0]  w_arb_onehot;
    logic [ID_W-1:0]            w_arb_idx;
    logic [LEN_W-1:0]           w_req_len;
    logic [LEN_W-1:0]           w_req_len_clamped;
    logic                       w_last_elem;

    uart_tx_rr_arbiter #(
        .N    (NUM_REQUESTERS),
        .ID_W (ID_W)
    ) u_arbiter (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_hit   (w_hit),
        .o_grant (w_arb_onehot),
        .o_idx   (w_arb_idx)
    );

    assign w_req_len         = i_req_length[w_arb_idx];
    assign w_req_len_clamped = (w_req_len > LEN_W'(MAX_LENGTH)) ? LEN_W'(MAX_LENGTH) : w_req_len;
    assign w_last_elem       = (LEN_W'(r_rd_index) + LEN_W'(1)) == r_len;

    always_comb begin
        w_state_d    = r_state;
        w_ptr_d      = r_ptr;
        w_grant_id_d = r_grant_id;
        w_rd_sel_d   = r_rd_sel;
        w_rd_index_d = r_rd_index;
        w_len_d      = r_len;
        w_gap_len_d  = r_gap_len;
        w_gap_cnt_d  = r_gap_cnt;
        w_busy_d     = r_busy;
        w_tx_en_d    = 1'b0;
        w_tx_data_d  = r_tx_data;
        w_req_done_d = '0;
`ifdef UART_TX_SCHED_SOURCE_HEADER_EN
        w_hdr_d      = r_hdr;
`endif

        unique case (r_state)
            StIdle: begin
                if (w_hit) begin
                    w_grant_id_d = w_arb_idx;
                    w_rd_sel_d   = w_arb_onehot;
                    w_busy_d     = 1'b1;
                    w_rd_index_d = '0;
                    w_len_d      = w_req_len_clamped;
                    w_gap_len_d  = i_gap_cycles;
`ifdef UART_TX_SCHED_SOURCE_HEADER_EN
                    w_hdr_d      = 1'b1;
                    w_state_d    = StHeader;
`else
                    w_state_d    = (w_req_len_clamped == '0) ? StDone : StFetch;
`endif
                end
            end
`ifdef UART_TX_SCHED_SOURCE_HEADER_EN
            StHeader: begin
                if (i_byte_tx_ready) begin
                    w_tx_en_d   = 1'b1;
                    w_tx_data_d = ELEMENT_WIDTH'(r_grant_id);
                    w_state_d   = StWaitAccept;
                end
            end
`endif
            StFetch: begin
                w_state_d = StSend;
            end
            StSend: begin
                if (i_byte_tx_ready) begin
                    w_tx_en_d   = 1'b1;
                    w_tx_data_d = i_rd_data[r_grant_id];
                    w_state_d   = StWaitAccept;
                end
            end
            StWaitAccept: begin
                if (!i_byte_tx_ready) begin
                    w_state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (i_byte_tx_ready) begin
`ifdef UART_TX_SCHED_SOURCE_HEADER_EN
                    if (r_hdr) begin
                        w_hdr_d   = 1'b0;
                        w_state_d = (r_len == '0) ? StDone : StFetch;
                    end else if (w_last_elem) begin
                        w_state_d = StDone;
                    end else begin
                        w_rd_index_d = r_rd_index + IDX_W'(1);
                        w_state_d    = StFetch;
                    end
`else
                    if (w_last_elem) begin
                        w_state_d = StDone;
                    end else begin
                        w_rd_index_d = r_rd_index + IDX_W'(1);
                        w_state_d    = StFetch;
                    end
`endif
                end
            end
            StDone: begin
                w_ptr_d = (r_grant_id == ID_W'(NUM_REQUESTERS - 1)) ? '0 : r_grant_id + ID_W'(1);
                if (r_gap_len == '0) begin
                    w_busy_d   = 1'b0;
                    w_rd_sel_d = '0;
                    w_state_d  = StIdle;
                end else begin
                    w_gap_cnt_d = r_gap_len;
                    w_state_d   = StGap;
                end
            end
            StGap: begin
                // Counter was loaded with the gap length, so leaving at 1 gives exactly that many cycles.
                if (r_gap_cnt <= GAP_WIDTH'(1)) begin
                    w_gap_cnt_d = '0;
                    w_busy_d    = 1'b0;
                    w_rd_sel_d  = '0;
                    w_state_d   = StIdle;
                end else begin
                    w_gap_cnt_d = r_gap_cnt - GAP_WIDTH'(1);
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        // DONE always lasts one cycle, so this yields a single-cycle pulse.
        if (w_state_d == StDone) begin
            w_req_done_d = w_rd_sel_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_ptr      <= '0;
            r_grant_id <= '0;
            r_rd_sel   <= '0;
            r_rd_index <= '0;
            r_len      <= '0;
            r_gap_len  <= '0;
            r_gap_cnt  <= '0;
            r_busy     <= 1'b0;
            r_tx_en    <= 1'b0;
            r_tx_data  <= '0;
            r_req_done <= '0;
`ifdef UART_TX_SCHED_SOURCE_HEADER_EN
            r_hdr      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_d;
            r_ptr      <= w_ptr_d;
            r_grant_id <= w_grant_id_d;
            r_rd_sel   <= w_rd_sel_d;
            r_rd_index <= w_rd_index_d;
            r_len      <= w_len_d;
            r_gap_len  <= w_gap_len_d;
            r_gap_cnt  <= w_gap_cnt_d;
            r_busy     <= w_busy_d;
            r_tx_en    <= w_tx_en_d;
            r_tx_data  <= w_tx_data_d;
            r_req_done <= w_req_done_d;
`ifdef UART_TX_SCHED_SOURCE_HEADER_EN
            r_hdr      <= w_hdr_d;
`endif
        end
    end

    assign o_req_done     = r_req_done;
    assign o_rd_sel       = r_rd_sel;
    assign o_rd_index     = r_rd_index;
    assign o_byte_tx_en   = r_tx_en;
    assign o_byte_tx_data = r_tx_data;
    assign o_busy         = r_busy;
    assign o_grant_id     = r_grant_id;

endmodule

// File: tb/tb_uart_tx_frame_scheduler.sv
// Directed self-checking bench for uart_tx_frame_scheduler with a cycle-stepped transmitter
// and indexed-read model; expectations adapt when UART_TX_SCHED_SOURCE_HEADER_EN is defined.
module tb_uart_tx_frame_scheduler;

    localparam int ByteTime = 4;
`ifdef UART_TX_SCHED_SOURCE_HEADER_EN
    localparam int HdrN = 1;
`else
    localparam int HdrN = 0;
`endif

    logic            clk;
    logic            rst;
    logic [3:0]      req_valid;
    logic [3:0][8:0] req_length;
    logic [3:0]      req_done;
    logic [3:0]      rd_sel;
    logic [7:0]      rd_index;
    logic [3:0][7:0] rd_data;
    logic [15:0]     gap_cycles;
    logic            tx_en;
    logic [7:0]      tx_data;
    logic            tx_ready;
    logic            busy;
    logic [1:0]      grant_id;

    uart_tx_frame_scheduler #(
        .NUM_REQUESTERS (4),
        .ELEMENT_WIDTH  (8),
        .MAX_LENGTH     (256),
        .GAP_WIDTH      (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_req_valid     (req_valid),
        .i_req_length    (req_length),
        .o_req_done      (req_done),
        .o_rd_sel        (rd_sel),
        .o_rd_index      (rd_index),
        .i_rd_data       (rd_data),
        .i_gap_cycles    (gap_cycles),
        .o_byte_tx_en    (tx_en),
        .o_byte_tx_data  (tx_data),
        .i_byte_tx_ready (tx_ready),
        .o_busy          (busy),
        .o_grant_id      (grant_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int tx_left = 0;
    int ready_rise_cyc = -1;
    logic [7:0] mem [4][8];
    logic [7:0] tx_q[$];
    int         tx_cyc_q[$];
    logic [3:0] done_q[$];
    int         done_cyc_q[$];
    int         grant_q[$];
    int         grant_cyc_q[$];
    int         busy_fall_q[$];
    logic       prev_en = 1'b0;
    logic       prev_busy = 1'b0;
    logic [3:0] prev_sel = '0;
    logic [7:0] prev_idx = '0;
    bit         dbl_en = 1'b0;

    function automatic logic [7:0] tx_at(input int i);
        return (i < tx_q.size()) ? tx_q[i] : 8'hxx;
    endfunction
    function automatic int icyc(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1000;
    endfunction
    function automatic logic [3:0] done_at(input int i);
        return (i < done_q.size()) ? done_q[i] : 4'hx;
    endfunction

    // One clock: sample DUT after the edge, then advance transmitter and read-port models.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (tx_en) begin
            tx_q.push_back(tx_data);
            tx_cyc_q.push_back(cyc);
            if (prev_en) dbl_en = 1'b1;
            tx_left  = ByteTime;
            tx_ready = 1'b0;
        end else if (tx_left > 0) begin
            tx_left--;
            if (tx_left == 0) begin
                tx_ready       = 1'b1;
                ready_rise_cyc = cyc;
            end
        end
        if (req_done != 4'b0) begin
            done_q.push_back(req_done);
            done_cyc_q.push_back(cyc);
        end
        if (rd_sel != 4'b0 && prev_sel == 4'b0) begin
            grant_q.push_back(int'(grant_id));
            grant_cyc_q.push_back(cyc);
        end
        if (!busy && prev_busy) busy_fall_q.push_back(cyc);
        for (int r = 0; r < 4; r++) rd_data[r] = mem[r][prev_idx[2:0]];
        prev_en   = tx_en;
        prev_sel  = rd_sel;
        prev_busy = busy;
        prev_idx  = rd_index;
    endtask

    task automatic clear_logs();
        tx_q.delete();
        tx_cyc_q.delete();
        done_q.delete();
        done_cyc_q.delete();
        grant_q.delete();
        grant_cyc_q.delete();
        busy_fall_q.delete();
    endtask

    task automatic run_until_done(input int n, input int bound, input string name);
        for (int i = 0; i < bound && done_q.size() < n; i++) step();
        checks++;
        if (done_q.size() < n) begin
            failures++;
            $display("FAIL %s_timeout: done pulses %0d, required %0d", name, done_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (tx_en !== 1'b0 || tx_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_tx: en=%b data=%h, required 0/00", tx_en, tx_data);
        end
        checks++;
        if (rd_sel !== 4'b0 || rd_index !== 8'h00) begin
            failures++;
            $display("FAIL reset_rd: sel=%b idx=%h, required 0/00", rd_sel, rd_index);
        end
        checks++;
        if (req_done !== 4'b0 || busy !== 1'b0 || grant_id !== 2'd0) begin
            failures++;
            $display("FAIL reset_ctl: done=%b busy=%b gid=%0d, required 0", req_done, busy, grant_id);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        int exp_g[4] = '{0, 1, 3, 0};
        clear_logs();
        for (int r = 0; r < 4; r++) req_length[r] = 9'd1;
        gap_cycles = 16'd0;
        req_valid  = 4'b1011;
        run_until_done(4, 800, "rr");
        req_valid = 4'b0;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (grant_q.size() != 4) begin
            failures++;
            $display("FAIL rr_grant_count: got %0d, required 4", grant_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (icyc(grant_q, i) != exp_g[i] || done_at(i) !== 4'(1 << exp_g[i])) begin
                failures++;
                $display("FAIL rr_order[%0d]: grant %0d done %b, required %0d / %b", i,
                         icyc(grant_q, i), done_at(i), exp_g[i], 4'(1 << exp_g[i]));
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (icyc(grant_cyc_q, i + 1) - icyc(done_cyc_q, i) != 2) begin
                failures++;
                $display("FAIL rr_regrant[%0d]: %0d cycles after done, required 2", i,
                         icyc(grant_cyc_q, i + 1) - icyc(done_cyc_q, i));
            end
        end
    endtask

    task automatic test_basic_frame();
        logic [7:0] exp_b[3] = '{8'hA1, 8'hB2, 8'hC3};
        clear_logs();
        mem[2][0] = 8'hA1;
        mem[2][1] = 8'hB2;
        mem[2][2] = 8'hC3;
        req_length[2] = 9'd3;
        gap_cycles    = 16'd0;
        req_valid     = 4'b0100;
        run_until_done(1, 200, "basic");
        req_valid = 4'b0;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (icyc(grant_q, 0) != 2 || grant_q.size() != 1) begin
            failures++;
            $display("FAIL basic_grant: got %0d (n=%0d), required 2", icyc(grant_q, 0), grant_q.size());
        end
        checks++;
        if (tx_q.size() != 3 + HdrN) begin
            failures++;
            $display("FAIL basic_tx_count: got %0d, required %0d", tx_q.size(), 3 + HdrN);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (tx_at(HdrN + k) !== exp_b[k]) begin
                failures++;
                $display("FAIL basic_byte[%0d]: got %h, required %h", k, tx_at(HdrN + k), exp_b[k]);
            end
        end
`ifdef UART_TX_SCHED_SOURCE_HEADER_EN
        checks++;
        if (tx_at(0) !== 8'h02) begin
            failures++;
            $display("FAIL basic_header: got %h, required 02", tx_at(0));
        end
`endif
        checks++;
        if (icyc(tx_cyc_q, 0) - icyc(grant_cyc_q, 0) != 2 - HdrN) begin
            failures++;
            $display("FAIL basic_first_tx_latency: got %0d, required %0d",
                     icyc(tx_cyc_q, 0) - icyc(grant_cyc_q, 0), 2 - HdrN);
        end
        checks++;
        if (done_q.size() != 1 || done_at(0) !== 4'b0100) begin
            failures++;
            $display("FAIL basic_done: got %b (n=%0d), required 0100 once", done_at(0), done_q.size());
        end
        checks++;
        if (icyc(done_cyc_q, 0) - ready_rise_cyc != 1) begin
            failures++;
            $display("FAIL basic_done_latency: got %0d, required 1", icyc(done_cyc_q, 0) - ready_rise_cyc);
        end
        checks++;
        if (icyc(busy_fall_q, 0) - icyc(done_cyc_q, 0) != 1) begin
            failures++;
            $display("FAIL basic_busy_fall: got %0d, required 1",
                     icyc(busy_fall_q, 0) - icyc(done_cyc_q, 0));
        end
    endtask

    task automatic test_zero_length();
        clear_logs();
        req_length[1] = 9'd0;
        gap_cycles    = 16'd0;
        req_valid     = 4'b0010;
        run_until_done(1, 100, "zero");
        req_valid = 4'b0;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (done_at(0) !== 4'b0010 || done_q.size() != 1) begin
            failures++;
            $display("FAIL zero_done: got %b (n=%0d), required 0010 once", done_at(0), done_q.size());
        end
        checks++;
        if (tx_q.size() != HdrN) begin
            failures++;
            $display("FAIL zero_tx_count: got %0d, required %0d", tx_q.size(), HdrN);
        end
`ifdef UART_TX_SCHED_SOURCE_HEADER_EN
        checks++;
        if (tx_at(0) !== 8'h01) begin
            failures++;
            $display("FAIL zero_header: got %h, required 01", tx_at(0));
        end
`else
        checks++;
        if (icyc(done_cyc_q, 0) != icyc(grant_cyc_q, 0)) begin
            failures++;
            $display("FAIL zero_done_timing: done at %0d, required grant cycle %0d",
                     icyc(done_cyc_q, 0), icyc(grant_cyc_q, 0));
        end
`endif
    endtask

    task automatic test_gap();
        int n_in_gap = 0;
        clear_logs();
        req_length[0] = 9'd1;
        gap_cycles    = 16'd10;
        req_valid     = 4'b0001;
        run_until_done(2, 400, "gap");
        req_valid = 4'b0;
        for (int i = 0; i < 15; i++) step();
        foreach (tx_cyc_q[i])
            if (tx_cyc_q[i] > icyc(done_cyc_q, 0) && tx_cyc_q[i] < icyc(grant_cyc_q, 1)) n_in_gap++;
        checks++;
        if (icyc(busy_fall_q, 0) - icyc(done_cyc_q, 0) != 11) begin
            failures++;
            $display("FAIL gap_idle_entry: got %0d, required 11",
                     icyc(busy_fall_q, 0) - icyc(done_cyc_q, 0));
        end
        checks++;
        if (icyc(grant_cyc_q, 1) - icyc(done_cyc_q, 0) != 12) begin
            failures++;
            $display("FAIL gap_regrant: got %0d, required 12",
                     icyc(grant_cyc_q, 1) - icyc(done_cyc_q, 0));
        end
        checks++;
        if (n_in_gap != 0) begin
            failures++;
            $display("FAIL gap_no_tx: got %0d sends, required 0", n_in_gap);
        end
    endtask

    task automatic test_ready_stall();
        int rel;
        clear_logs();
        mem[3][0]     = 8'h5E;
        req_length[3] = 9'd1;
        gap_cycles    = 16'd0;
        tx_ready      = 1'b0;
        req_valid     = 4'b1000;
        for (int i = 0; i < 52; i++) step();
        checks++;
        if (tx_q.size() != 0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL stall_no_tx: sends %0d busy %b, required 0/1", tx_q.size(), busy);
        end
        tx_ready = 1'b1;
        rel      = cyc;
        run_until_done(1, 100, "stall");
        req_valid = 4'b0;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (icyc(tx_cyc_q, 0) - rel != 1) begin
            failures++;
            $display("FAIL stall_release: got %0d, required 1", icyc(tx_cyc_q, 0) - rel);
        end
        checks++;
        if (tx_at(HdrN) !== 8'h5E) begin
            failures++;
            $display("FAIL stall_byte: got %h, required 5e", tx_at(HdrN));
        end
    endtask

    task automatic test_reset_midframe();
        clear_logs();
        for (int k = 0; k < 4; k++) mem[2][k] = 8'(8'h40 + k);
        req_length[2] = 9'd4;
        req_length[0] = 9'd2;
        gap_cycles    = 16'd0;
        req_valid     = 4'b0100;
        for (int i = 0; i < 200 && tx_q.size() < 2 + HdrN; i++) step();
        checks++;
        if (tx_q.size() < 2 + HdrN) begin
            failures++;
            $display("FAIL midrst_timeout: sends %0d, required %0d", tx_q.size(), 2 + HdrN);
        end
        rst = 1'b1;
        step();
        checks++;
        if (tx_en !== 1'b0 || tx_data !== 8'h00 || rd_index !== 8'h00) begin
            failures++;
            $display("FAIL midrst_tx: en=%b data=%h idx=%h, required 0", tx_en, tx_data, rd_index);
        end
        checks++;
        if (rd_sel !== 4'b0 || busy !== 1'b0 || grant_id !== 2'd0 || req_done !== 4'b0) begin
            failures++;
            $display("FAIL midrst_ctl: sel=%b busy=%b gid=%0d done=%b, required 0",
                     rd_sel, busy, grant_id, req_done);
        end
        checks++;
        if (done_q.size() != 0) begin
            failures++;
            $display("FAIL midrst_no_done: got %0d pulses, required 0", done_q.size());
        end
        tx_left   = 0;
        tx_ready  = 1'b1;
        req_valid = 4'b0101;
        rst       = 1'b0;
        clear_logs();
        run_until_done(1, 200, "midrst");
        req_valid = 4'b0;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (icyc(grant_q, 0) != 0 || done_at(0) !== 4'b0001) begin
            failures++;
            $display("FAIL midrst_regrant: grant %0d done %b, required 0 / 0001",
                     icyc(grant_q, 0), done_at(0));
        end
    endtask

    task automatic test_tx_en_spacing();
        checks++;
        if (dbl_en) begin
            failures++;
            $display("FAIL tx_en_spacing: got back-to-back pulse, required none");
        end
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_length = '0;
        rd_data    = '0;
        gap_cycles = '0;
        tx_ready   = 1'b1;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 8; k++) mem[r][k] = 8'(r * 16 + k);
        test_reset();
        test_round_robin();
        test_basic_frame();
        test_zero_length();
        test_gap();
        test_ready_stall();
        test_reset_midframe();
        test_tx_en_spacing();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
